// File: rtl/dmem_if.sv
// Request/response bus between the load/store unit (master) and the data-memory responder (slave).
// Lane-rotated byte-enabled requests go in; lane-rotated read data comes back with a one-cycle pulse.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: performs one lane-rotated, byte-enabled request at a time on a word array,
// splitting wrapped-enable accesses (offset lanes below ofs) into word A then word A+1.
module dmem_responder #(
    parameter int ADDR_W = 12
) (
    input  logic   clk,
    input  logic   rst_n,
    dmem_if.slave  bus
);
    localparam int WORD_W = ADDR_W - 2;
    localparam int DEPTH  = 1 << WORD_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PART_A,
        S_PART_B,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_we;
    logic [WORD_W-1:0]   r_word;
    logic [1:0]          r_ofs;
    logic [3:0]          r_be;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic [31:0]         r_rsp_rdata;
    logic [31:0]         r_mem [DEPTH];

    logic                w_accept;
    logic [3:0]          w_lane_hi;
    logic [3:0]          w_mask_a;
    logic [3:0]          w_mask_b;
    logic                w_split;
    logic [3:0]          w_part_mask;
    logic [31:0]         w_part_bits;
    logic [WORD_W-1:0]   w_mem_idx;
    logic                w_mem_we;
    logic [31:0]         w_mem_rd;
    logic [31:0]         w_rdata_nxt;
    logic                w_unused_addr_hi;

    assign w_accept         = bus.req_valid && (r_state == S_IDLE);
    assign w_unused_addr_hi = ^bus.req_addr[31:ADDR_W];

    // Lanes at or above the byte offset belong to word A; wrapped lanes below it belong to word A+1.
    assign w_lane_hi = 4'b1111 << r_ofs;
    assign w_mask_a  = r_be & w_lane_hi;
    assign w_mask_b  = r_be & ~w_lane_hi;
    assign w_split   = |w_mask_b;

    assign w_part_bits = {{8{w_part_mask[3]}}, {8{w_part_mask[2]}},
                          {8{w_part_mask[1]}}, {8{w_part_mask[0]}}};
    assign w_mem_rd    = r_mem[w_mem_idx];

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_part_mask = 4'b0000;
        w_mem_idx   = r_word;
        w_mem_we    = 1'b0;
        w_rdata_nxt = r_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_PART_A;
            end
            S_PART_A: begin
                w_part_mask = w_mask_a;
                w_mem_we    = r_we;
                w_rdata_nxt = r_we ? 32'h0 : (w_mem_rd & w_part_bits);
                w_state_nxt = w_split ? S_PART_B : S_RESP;
            end
            S_PART_B: begin
                w_part_mask = w_mask_b;
                w_mem_idx   = r_word + 1'b1;
                w_mem_we    = r_we;
                w_rdata_nxt = r_we ? 32'h0 : ((r_rdata & ~w_part_bits) | (w_mem_rd & w_part_bits));
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_word      <= '0;
            r_ofs       <= 2'b00;
            r_be        <= 4'b0000;
            r_wdata     <= 32'h0;
            r_rdata     <= 32'h0;
            r_rsp_rdata <= 32'h0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_word  <= bus.req_addr[ADDR_W-1:2];
                r_ofs   <= bus.req_addr[1:0];
                r_be    <= bus.req_be;
                r_wdata <= bus.req_wdata;
            end
            r_rdata <= w_rdata_nxt;
            // The visible read data only changes as a response is launched, so it holds between responses.
            if (w_state_nxt == S_RESP) r_rsp_rdata <= w_rdata_nxt;
        end
    end

    // NOTE: the array has no reset; its contents are undefined until written, as for a real SRAM macro.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_part_mask[i]) r_mem[w_mem_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a byte-addressed memory model predicts ready/valid/rdata every cycle,
// and directed requests pin literal read data and latencies.
module tb_dmem_responder;
    localparam int ADDR_W = 12;
    localparam int NBYTES = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_if bus ();

    dmem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: a plain byte array addressed modulo 2^ADDR_W.
    logic [7:0]  m_mem [NBYTES];
    bit          m_known [NBYTES];
    int          cyc       = 0;
    int          m_free_at = 0;
    int          m_rsp_at  = -1;
    logic [31:0] m_rsp_data  = 32'h0;
    logic [31:0] m_rsp_mask  = 32'hFFFF_FFFF;
    logic [31:0] m_last_data = 32'h0;
    logic [31:0] m_last_mask = 32'hFFFF_FFFF;
    bit          p_active = 0;
    bit          p_we     = 0;
    int          p_c0     = 0;
    int          p_badr [4];
    bit          p_second [4];
    logic [3:0]  p_en   = 4'b0000;
    logic [31:0] p_data = 32'h0;
    int          rsp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic void model_reset();
        p_active    = 0;
        m_rsp_at    = -1;
        m_free_at   = 0;
        m_last_data = 32'h0;
        m_last_mask = 32'hFFFF_FFFF;
    endfunction

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        int c;
        int ofs;
        int base;
        bit split;
        c = cyc;
        if (bus.rsp_valid) rsp_cnt++;
        if (!rst_n) begin
            model_reset();
        end else begin
            // First-word lanes land one cycle after accept, wrapped lanes one cycle later.
            if (p_active && p_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (p_en[i] && ((!p_second[i] && c == p_c0 + 1) || (p_second[i] && c == p_c0 + 2))) begin
                        m_mem[p_badr[i]]   = p_data[8*i +: 8];
                        m_known[p_badr[i]] = 1;
                    end
                end
            end
            if (bus.req_valid && c >= m_free_at) begin
                ofs        = int'(bus.req_addr[1:0]);
                base       = int'(bus.req_addr[ADDR_W-1:0]) & ~3;
                split      = 0;
                m_rsp_data = 32'h0;
                m_rsp_mask = 32'hFFFF_FFFF;
                for (int i = 0; i < 4; i++) begin
                    p_en[i] = bus.req_be[i];
                    if (i >= ofs) begin
                        p_badr[i]   = base + i;
                        p_second[i] = 0;
                    end else begin
                        p_badr[i]   = (base + 4 + i) % NBYTES;
                        p_second[i] = 1;
                        if (p_en[i]) split = 1;
                    end
                    if (!bus.req_we && p_en[i]) begin
                        if (m_known[p_badr[i]]) m_rsp_data[8*i +: 8] = m_mem[p_badr[i]];
                        else                    m_rsp_mask[8*i +: 8] = 8'h00;
                    end
                end
                p_active  = 1;
                p_we      = bus.req_we;
                p_data    = bus.req_wdata;
                p_c0      = c;
                m_rsp_at  = c + (split ? 3 : 2);
                m_free_at = m_rsp_at + 1;
            end
        end
        cyc = c + 1;
        if (rst_n && cyc == m_rsp_at) begin
            m_last_data = m_rsp_data;
            m_last_mask = m_rsp_mask;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("ready", {31'b0, bus.req_ready}, {31'b0, (cyc >= m_free_at)});
            check("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, (cyc == m_rsp_at)});
            check("rsp_rdata", bus.rsp_rdata & m_last_mask, m_last_data & m_last_mask);
        end
    end

    // Called at a negedge right after the accept edge; returns at the negedge of the response cycle.
    task automatic wait_rsp(input string name, input int exp_lat, input logic [31:0] exp_rd,
                            input logic [31:0] exp_mask);
        int lat;
        bit got;
        lat = 1;
        got = 0;
        while (!got && lat < 16) begin
            if (bus.rsp_valid) got = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_rdata"}, bus.rsp_rdata & exp_mask, exp_rd & exp_mask);
    endtask

    task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, input int exp_lat,
                          input logic [31:0] exp_rd, input logic [31:0] exp_mask);
        int n;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_be    = be;
        bus.req_wdata = wd;
        n = 0;
        while (!bus.req_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check({name, "_accept"}, {31'b0, bus.req_ready}, 32'h1);
            bus.req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_wdata = 32'h0;
        wait_rsp(name, exp_lat, exp_rd, exp_mask);
    endtask

    initial begin
        int k;
        int c0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_be    = 4'b0000;
        bus.req_wdata = 32'h0;

        repeat (3) @(negedge clk);
        check("reset_ready", {31'b0, bus.req_ready}, 32'h1);
        check("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        do_req("wr_word", 1, 32'h010, 4'b1111, 32'hDEADBEEF, 2, 32'h0, 32'hFFFF_FFFF);
        do_req("rd_word", 0, 32'h010, 4'b1111, 32'h0, 2, 32'hDEADBEEF, 32'hFFFF_FFFF);
        do_req("wr_be0", 1, 32'h010, 4'b0000, 32'hFFFFFFFF, 2, 32'h0, 32'hFFFF_FFFF);
        do_req("rd_be0", 0, 32'h010, 4'b0000, 32'h0, 2, 32'h0, 32'hFFFF_FFFF);
        do_req("rd_after_be0", 0, 32'h010, 4'b1111, 32'h0, 2, 32'hDEADBEEF, 32'hFFFF_FFFF);

        do_req("zero_020", 1, 32'h020, 4'b1111, 32'h0, 2, 32'h0, 32'hFFFF_FFFF);
        do_req("wr_byte", 1, 32'h021, 4'b0010, 32'h55555555, 2, 32'h0, 32'hFFFF_FFFF);
        do_req("rd_020", 0, 32'h020, 4'b1111, 32'h0, 2, 32'h00005500, 32'hFFFF_FFFF);
        do_req("rd_byte3", 0, 32'h023, 4'b1000, 32'h0, 2, 32'h0, 32'hFFFF_FFFF);

        do_req("zero_030", 1, 32'h030, 4'b1111, 32'h0, 2, 32'h0, 32'hFFFF_FFFF);
        do_req("zero_034", 1, 32'h034, 4'b1111, 32'h0, 2, 32'h0, 32'hFFFF_FFFF);
        do_req("wr_split", 1, 32'h033, 4'b1001, 32'hBB0000AA, 3, 32'h0, 32'hFFFF_FFFF);
        do_req("rd_030", 0, 32'h030, 4'b1111, 32'h0, 2, 32'hBB000000, 32'hFFFF_FFFF);
        do_req("rd_034", 0, 32'h034, 4'b1111, 32'h0, 2, 32'h000000AA, 32'hFFFF_FFFF);
        do_req("rd_split", 0, 32'h033, 4'b1001, 32'h0, 3, 32'hBB0000AA, 32'hFFFF_FFFF);

        do_req("wr_wrap", 1, 32'hFFF, 4'b1001, 32'h11000022, 3, 32'h0, 32'hFFFF_FFFF);
        do_req("rd_ffc", 0, 32'hFFC, 4'b1111, 32'h0, 2, 32'h11000000, 32'hFF00_0000);
        do_req("rd_000", 0, 32'h000, 4'b1111, 32'h0, 2, 32'h00000022, 32'h0000_00FF);
        do_req("rd_wrap", 0, 32'hFFF, 4'b1001, 32'h0, 3, 32'h11000022, 32'hFFFF_FFFF);

        // Two requests behind one continuously asserted req_valid.
        @(negedge clk);
        c0 = rsp_cnt;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h050;
        bus.req_be    = 4'b1111;
        bus.req_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        bus.req_we    = 1'b0;
        bus.req_wdata = 32'h0;
        k = 1;
        while (!bus.req_ready && k < 16) begin
            @(negedge clk);
            k++;
        end
        check("bp_gap", 32'(k), 32'd3);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_rsp("bp_rd", 2, 32'hA5A5A5A5, 32'hFFFF_FFFF);
        @(negedge clk);
        check("bp_pulses", 32'(rsp_cnt - c0), 32'd2);

        // Reset while the second half of a split write is pending.
        do_req("preload_044", 1, 32'h044, 4'b1111, 32'h12345678, 2, 32'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        c0 = rsp_cnt;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h043;
        bus.req_be    = 4'b1001;
        bus.req_wdata = 32'hEE0000FF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready_during", {31'b0, bus.req_ready}, 32'h1);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready_after", {31'b0, bus.req_ready}, 32'h1);
        check("rst_no_rsp", 32'(rsp_cnt - c0), 32'd0);
        do_req("rd_044", 0, 32'h044, 4'b1111, 32'h0, 2, 32'h12345678, 32'hFFFF_FFFF);
        do_req("rd_040", 0, 32'h040, 4'b1111, 32'h0, 2, 32'hEE000000, 32'hFF00_0000);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "timeout");
    end
endmodule
